// File: rtl/cell_bus_master_if.sv
// Host request/response handshake plus the shared register-cell bus.
// master = the bus initiator, slave = host and cell bank.
interface cell_bus_master_if #(
  parameter int NUM_CELLS = 16,
  parameter int WORD_SIZE = 8,
  parameter int ADDR_W    = $clog2(NUM_CELLS)
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDR_W-1:0]    req_addr;
  logic [WORD_SIZE-1:0] req_wdata;
  logic                 rsp_valid;
  logic [WORD_SIZE-1:0] rsp_rdata;
  logic                 rsp_err;
  logic [NUM_CELLS-1:0] cell_sel;
  logic                 cell_we;
  logic [WORD_SIZE-1:0] cell_wdata;
  logic [WORD_SIZE-1:0] cell_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, cell_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, cell_sel, cell_we, cell_wdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, cell_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, cell_sel, cell_we, cell_wdata
  );
endinterface

// File: rtl/cell_bus_master.sv
// Register-cell bus initiator: one host request at a time, one-hot cell access,
// optional write readback check, single-cycle response strobe.
module cell_bus_master #(
  parameter int NUM_CELLS = 16,
  parameter int WORD_SIZE = 8,
  parameter int ADDR_W    = $clog2(NUM_CELLS),
  parameter bit VERIFY    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  cell_bus_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, WR, RB, RD, ERR, RSP} state_t;

  localparam logic [ADDR_W:0] NUM_CELLS_W = (ADDR_W + 1)'(NUM_CELLS);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 req_oor;
  logic [NUM_CELLS-1:0] sel_dec;
  logic                 bus_on;

  // Zero-extended compare so out-of-range codes never alias onto a cell.
  assign req_oor = ({1'b0, bus.req_addr} >= NUM_CELLS_W);

  generate
    for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_sel
      assign sel_dec[gi] = (addr_q == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_oor)            state_d = ERR;
          else if (bus.req_write) state_d = WR;
          else                    state_d = RD;
        end
      end
      WR:          state_d = VERIFY ? RB : RSP;
      RB, RD, ERR: state_d = RSP;
      RSP:         state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Response registers load on the edge entering RSP and then hold.
  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
        end
      end
      WR: begin
        if (!VERIFY) begin
          rsp_rdata_d = wdata_q;
          rsp_err_d   = 1'b0;
        end
      end
      RB: begin
        rsp_rdata_d = bus.cell_rdata;
        rsp_err_d   = (bus.cell_rdata != wdata_q);
      end
      RD: begin
        rsp_rdata_d = bus.cell_rdata;
        rsp_err_d   = 1'b0;
      end
      ERR: begin
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are gated by rst so a write in flight never reaches the cells.
  always_comb begin
    bus_on         = !rst && (state_q == WR || state_q == RB || state_q == RD);
    bus.req_ready  = !rst && (state_q == IDLE);
    bus.rsp_valid  = !rst && (state_q == RSP);
    bus.rsp_rdata  = rst ? '0 : rsp_rdata_q;
    bus.rsp_err    = !rst && rsp_err_q;
    bus.cell_sel   = bus_on ? sel_dec : '0;
    bus.cell_we    = !rst && (state_q == WR);
    bus.cell_wdata = rst ? '0 : wdata_q;
  end

endmodule

// File: tb/tb_cell_bus_master.sv
// Directed bench: a 12-cell verifying master (cell 5 stuck at zero) and a
// 16-cell non-verifying master, each driving a small behavioural cell bank.
module tb_cell_bus_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cell_init = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cell_bus_master_if #(.NUM_CELLS(12), .WORD_SIZE(8), .ADDR_W(4)) ifa ();
  cell_bus_master_if #(.NUM_CELLS(16), .WORD_SIZE(8), .ADDR_W(4)) ifb ();

  cell_bus_master #(.NUM_CELLS(12), .WORD_SIZE(8), .ADDR_W(4), .VERIFY(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  cell_bus_master #(.NUM_CELLS(16), .WORD_SIZE(8), .ADDR_W(4), .VERIFY(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  logic [7:0] mem_a [12];
  logic [7:0] mem_b [16];
  logic [7:0] rdata_a, rdata_b;

  // Cells load i*17 once at start-up only; later resets leave them untouched.
  always @(posedge clk) begin
    for (int i = 0; i < 12; i++) begin
      if (cell_init) mem_a[i] <= 8'(i * 17);
      else if (ifa.cell_we && ifa.cell_sel[i]) mem_a[i] <= ifa.cell_wdata;
    end
    for (int i = 0; i < 16; i++) begin
      if (cell_init) mem_b[i] <= 8'(i * 17);
      else if (ifb.cell_we && ifb.cell_sel[i]) mem_b[i] <= ifb.cell_wdata;
    end
  end

  always_comb begin
    rdata_a = '0;
    for (int i = 0; i < 12; i++)
      if (ifa.cell_sel[i] && i != 5) rdata_a = rdata_a | mem_a[i];
  end

  always_comb begin
    rdata_b = '0;
    for (int i = 0; i < 16; i++)
      if (ifb.cell_sel[i]) rdata_b = rdata_b | mem_b[i];
  end

  assign ifa.cell_rdata = rdata_a;
  assign ifb.cell_rdata = rdata_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("sel_onehot0_a", 32'($onehot0(ifa.cell_sel)), 32'd1);
    chk("sel_onehot0_b", 32'($onehot0(ifb.cell_sel)), 32'd1);
  end

  // One request with fixed expected latency, bus activity and response.
  task automatic txn(input bit use_b, input bit wr, input logic [3:0] addr,
                     input logic [7:0] wd, input bit oor, input logic [7:0] exp_rd,
                     input bit exp_err, input string tag);
    int          lat;
    logic [31:0] exp_sel;
    logic [31:0] sel;
    logic        we, rv, re;
    logic [7:0]  rd;
    lat     = (wr && !oor && !use_b) ? 3 : 2;
    exp_sel = oor ? 32'd0 : (32'd1 << addr);
    if (use_b) begin
      ifb.req_valid = 1'b1; ifb.req_write = wr; ifb.req_addr = addr; ifb.req_wdata = wd;
    end else begin
      ifa.req_valid = 1'b1; ifa.req_write = wr; ifa.req_addr = addr; ifa.req_wdata = wd;
    end
    chk({tag, "_ready"}, 32'(use_b ? ifb.req_ready : ifa.req_ready), 32'd1);
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
    ifb.req_valid = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      sel = use_b ? 32'(ifb.cell_sel) : 32'(ifa.cell_sel);
      we  = use_b ? ifb.cell_we : ifa.cell_we;
      rv  = use_b ? ifb.rsp_valid : ifa.rsp_valid;
      rd  = use_b ? ifb.rsp_rdata : ifa.rsp_rdata;
      re  = use_b ? ifb.rsp_err : ifa.rsp_err;
      if (c == 1) begin
        chk({tag, "_sel1"}, sel, exp_sel);
        chk({tag, "_we1"}, 32'(we), 32'(wr && !oor));
      end
      if (c == 2 && lat == 3) begin
        chk({tag, "_sel_rb"}, sel, exp_sel);
        chk({tag, "_we_rb"}, 32'(we), 32'd0);
      end
      if (c < lat) chk({tag, "_early_rsp"}, 32'(rv), 32'd0);
      else begin
        chk({tag, "_rsp_valid"}, 32'(rv), 32'd1);
        chk({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
        chk({tag, "_err"}, 32'(re), 32'(exp_err));
      end
    end
    @(posedge clk); #1;
    chk({tag, "_rsp_one_cycle"}, 32'(use_b ? ifb.rsp_valid : ifa.rsp_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(use_b ? ifb.req_ready : ifa.req_ready), 32'd1);
    $display("txn %s: wr=%0d addr=%0d wdata=0x%0h exp_rdata=0x%0h exp_err=%0d",
             tag, wr, addr, wd, exp_rd, exp_err);
  endtask

  initial begin
    int         n, we_cnt, rsp_cnt;
    bit         acc;
    logic [31:0] acc_cyc [3];
    logic [31:0] sel_seen [3];

    ifa.req_valid = 1'b0; ifa.req_write = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0;
    ifb.req_valid = 1'b0; ifb.req_write = 1'b0; ifb.req_addr = '0; ifb.req_wdata = '0;

    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready", 32'(ifa.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(ifa.rsp_err), 32'd0);
    chk("rst_rsp_rdata", 32'(ifa.rsp_rdata), 32'd0);
    chk("rst_cell_we", 32'(ifa.cell_we), 32'd0);
    chk("rst_cell_sel", 32'(ifa.cell_sel), 32'd0);
    chk("rst_cell_wdata", 32'(ifa.cell_wdata), 32'd0);
    rst = 1'b0;
    cell_init = 1'b0;
    #1;
    chk("post_rst_ready", 32'(ifa.req_ready), 32'd1);
    $display("txn reset: outputs checked during and after reset");

    txn(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, 8'hA5, 1'b0, "wr3");
    txn(1'b0, 1'b0, 4'd3, 8'h00, 1'b0, 8'hA5, 1'b0, "rd3");
    txn(1'b0, 1'b1, 4'd5, 8'h3C, 1'b0, 8'h00, 1'b1, "wr5_mismatch");
    txn(1'b0, 1'b0, 4'd13, 8'h00, 1'b1, 8'h00, 1'b1, "rd13_oor");
    chk("hold_err", 32'(ifa.rsp_err), 32'd1);
    chk("hold_rdata", 32'(ifa.rsp_rdata), 32'd0);

    // Back-to-back writes with req_valid held high.
    n = 0; we_cnt = 0; rsp_cnt = 0;
    for (int k = 0; k < 3; k++) begin acc_cyc[k] = 32'hFFFF; sel_seen[k] = '0; end
    ifa.req_valid = 1'b1; ifa.req_write = 1'b1; ifa.req_addr = 4'd0; ifa.req_wdata = 8'h10;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (ifa.cell_we) begin
        if (we_cnt < 3) sel_seen[we_cnt] = 32'(ifa.cell_sel);
        we_cnt++;
      end
      if (ifa.rsp_valid) rsp_cnt++;
      acc = ifa.req_valid && ifa.req_ready;
      if (acc && n < 3) acc_cyc[n] = 32'(cyc);
      @(posedge clk); #1;
      if (acc) begin
        n++;
        if (n == 3) ifa.req_valid = 1'b0;
        else begin ifa.req_addr = 4'(n); ifa.req_wdata = 8'(8'h10 + n); end
      end
    end
    chk("b2b_acc0", acc_cyc[0], 32'd0);
    chk("b2b_acc1", acc_cyc[1], 32'd4);
    chk("b2b_acc2", acc_cyc[2], 32'd8);
    chk("b2b_we_cnt", 32'(we_cnt), 32'd3);
    chk("b2b_sel0", sel_seen[0], 32'h1);
    chk("b2b_sel1", sel_seen[1], 32'h2);
    chk("b2b_sel2", sel_seen[2], 32'h4);
    chk("b2b_rsp_cnt", 32'(rsp_cnt), 32'd3);
    $display("txn b2b: accepts=%0d we_pulses=%0d rsp=%0d", n, we_cnt, rsp_cnt);

    // Reset asserted during the WR cycle of a write to cell 7.
    ifa.req_valid = 1'b1; ifa.req_write = 1'b1; ifa.req_addr = 4'd7; ifa.req_wdata = 8'hFF;
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
    chk("abort_we_before_rst", 32'(ifa.cell_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_we_in_rst", 32'(ifa.cell_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(ifa.req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("abort_no_rsp", 32'(ifa.rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    $display("txn abort: write to cell 7 dropped by reset");
    txn(1'b0, 1'b0, 4'd7, 8'h00, 1'b0, 8'h77, 1'b0, "rd7_after_abort");

    txn(1'b1, 1'b1, 4'd2, 8'h11, 1'b0, 8'h11, 1'b0, "nv_wr2");
    txn(1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 8'h11, 1'b0, "nv_rd2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
